// File: rtl/speech_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speech_pkg
//  Description : Shared types and constants for the speech command confirm
//                stage: command encoding, result bus width and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package speech_pkg;

  // Classifier / command encoding. CMD_RSVD behaves exactly like CMD_NONE.
  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_ON   = 2'd1,
    CMD_OFF  = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_e;

  localparam int CMD_W = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAND     = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

  // True for classes that carry a real command.
  function automatic logic is_cmd(input logic [1:0] cls);
    return (cls == CMD_ON) || (cls == CMD_OFF);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmd_hold_timer.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_hold_timer
//  Description : Restartable interval timer built on a loadable down-counter.
//                A start pulse (re)loads CYCLES-1; the counter then runs down
//                and raises expire for the single cycle in which it sits at
//                zero, after which it goes inactive. CYCLES == 0 disables it.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   system clock
//    rst_n  in   asynchronous active-low reset
//    start  in   load and (re)start the interval; overrides a running count
//    expire out  high in the last cycle of the interval
// ============================================================================
module cmd_hold_timer #(
  parameter int CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic expire
);

  localparam int             CNT_W  = (CYCLES > 0) ? $clog2(CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'((CYCLES > 0) ? CYCLES - 1 : 0);
  localparam logic           c_enabled = (CYCLES > 0);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start) begin
      active_d = c_enabled;
      cnt_d    = c_last;
    end else if (active_q) begin
      // Stop at zero rather than wrapping.
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  assign expire = active_q && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/cmd_confirm.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_confirm
//  Description : Confirms a speech command after CONFIRM_FRAMES consecutive
//                identical non-zero classifier frames, drives it on cmd_data
//                for HOLD_CYCLES, and blocks new frames for COOLDOWN_CYCLES
//                after each confirmation.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk          in   system clock
//    rst_n        in   asynchronous active-low reset
//    frame_valid  in   classifier frame decision valid
//    frame_class  in   0 silence, 1 on, 2 off, 3 reserved (as silence)
//    frame_ready  out  frame accepted this cycle when valid (registered)
//    cmd_data     out  confirmed command, zero-extended to CMD_W
//    cmd_valid    out  one-cycle pulse on every cmd_data change
//    busy         out  high in CAND or COOLDOWN
// ============================================================================
module cmd_confirm #(
  parameter int CONFIRM_FRAMES  = 3,
  parameter int HOLD_CYCLES     = 200_000_000,
  parameter int COOLDOWN_CYCLES = 1_000_000,
  parameter int CMD_W           = speech_pkg::CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_valid,
  input  logic [1:0]       frame_class,
  output logic             frame_ready,
  output logic [CMD_W-1:0] cmd_data,
  output logic             cmd_valid,
  output logic             busy
);

  import speech_pkg::*;

  localparam int               CNT_W      = $clog2(CONFIRM_FRAMES + 1);
  // cnt holds frames seen so far; confirming happens when cnt+1 reaches N.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CONFIRM_FRAMES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_e           state_q,       state_d;
  cmd_e             cand_q,        cand_d;
  logic [CNT_W-1:0] cnt_q,         cnt_d;
  cmd_e             cmd_q,         cmd_d;
  logic             cmd_valid_q,   cmd_valid_d;
  logic             frame_ready_q, frame_ready_d;
  logic             busy_q,        busy_d;

  logic accept;
  logic confirm;
  logic hold_expire;
  logic cd_expire;

  assign accept = frame_valid && frame_ready_q;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    confirm = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept && is_cmd(frame_class)) begin
          cand_d = cmd_e'(frame_class);
          if (CONFIRM_FRAMES == 1) begin
            confirm = 1'b1;
          end else begin
            cnt_d   = c_cnt_one;
            state_d = CAND;
          end
        end
      end

      CAND: begin
        if (accept) begin
          if (!is_cmd(frame_class)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cmd_e'(frame_class) == cand_q) begin
            if (cnt_q == c_cnt_last) begin
              confirm = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            // A different command restarts the streak with itself as frame 1.
            cand_d = cmd_e'(frame_class);
            cnt_d  = c_cnt_one;
          end
        end
      end

      COOLDOWN: begin
        if (cd_expire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Confirm takes priority over a simultaneous hold timeout.
    if (confirm) begin
      cmd_d   = cand_d;
      cnt_d   = '0;
      state_d = (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
    end else if (hold_expire) begin
      cmd_d = CMD_NONE;
    end
  end

  assign cmd_valid_d   = (cmd_d != cmd_q);
  assign frame_ready_d = (state_d != COOLDOWN);
  assign busy_d        = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cand_q        <= CMD_NONE;
      cnt_q         <= '0;
      cmd_q         <= CMD_NONE;
      cmd_valid_q   <= 1'b0;
      frame_ready_q <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      cmd_q         <= cmd_d;
      cmd_valid_q   <= cmd_valid_d;
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
    end
  end

  // Hold timer: every confirm restarts it; cmd_data is non-zero exactly
  // while it is running.
  cmd_hold_timer #(
    .CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (confirm),
    .expire (hold_expire)
  );

  // Cooldown timer: only started on a confirm that enters COOLDOWN.
  cmd_hold_timer #(
    .CYCLES (COOLDOWN_CYCLES)
  ) u_cooldown_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (confirm),
    .expire (cd_expire)
  );

  assign frame_ready = frame_ready_q;
  assign cmd_data    = {{(CMD_W-2){1'b0}}, cmd_q};
  assign cmd_valid   = cmd_valid_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cmd_confirm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmd_confirm
//  Description : Self-checking bench for cmd_confirm (CONFIRM=3, HOLD=20,
//                COOLDOWN=5). Expected cmd_valid events (value and cycle) are
//                queued by the stimulus; a monitor pops them on each pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_confirm;

  localparam int CONFIRM = 3;
  localparam int HOLD    = 20;
  localparam int CD      = 5;
  localparam int W       = 12;

  logic         clk;
  logic         rst_n;
  logic         frame_valid;
  logic [1:0]   frame_class;
  logic         frame_ready;
  logic [W-1:0] cmd_data;
  logic         cmd_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  cmd_confirm #(
    .CONFIRM_FRAMES  (CONFIRM),
    .HOLD_CYCLES     (HOLD),
    .COOLDOWN_CYCLES (CD),
    .CMD_W           (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .frame_class (frame_class),
    .frame_ready (frame_ready),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cmd_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pulse_unexpected: got cmd_data=%0d at cyc=%0d, required no pulse", cmd_data, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (cmd_data !== mon_e.data || cyc != mon_e.cyc) begin
          bad++;
          $display("FAIL pulse: got data=%0d cyc=%0d, required data=%0d cyc=%0d",
                   cmd_data, cyc, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d (cyc=%0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input logic [W-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Present one frame from a negedge; returns the cycle number of the
  // accepting posedge (outputs it updated are visible at negedge cyc==e).
  task automatic send(input logic [1:0] c, output int e);
    int n;
    n = 0;
    @(negedge clk);
    frame_valid = 1'b1;
    frame_class = c;
    while (!frame_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!frame_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: frame_ready=0 after %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    e = cyc;
    frame_valid = 1'b0;
    frame_class = 2'd0;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  initial begin
    int e, e1, e2, lows;
    rst_n       = 1'b0;
    frame_valid = 1'b0;
    frame_class = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_data", 32'(cmd_data), 0);
    chk("rst_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_frame_ready", 32'(frame_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1 + 4: three class-1 frames confirm, 5-cycle cooldown, 20-cycle hold.
    send(2'd1, e);
    send(2'd1, e);
    send(2'd1, e1);
    expect_pulse(12'd1, e1);
    expect_pulse(12'd0, e1 + HOLD);
    lows = 0;
    @(negedge clk);
    chk("t1_cmd_data", 32'(cmd_data), 1);
    chk("t1_busy", 32'(busy), 1);
    if (!frame_ready) lows++;
    repeat (7) begin
      @(negedge clk);
      if (!frame_ready) lows++;
    end
    chk("t1_ready_low_cycles", 32'(lows), CD);
    wait_cyc(e1 + HOLD - 1);
    chk("t4_hold_before", 32'(cmd_data), 1);
    wait_cyc(e1 + HOLD);
    chk("t4_hold_expired", 32'(cmd_data), 0);
    wait_cyc(e1 + HOLD + 2);

    // 2: 1,1,2,2,2 -> confirm class 2 only on the fifth frame.
    send(2'd1, e);
    send(2'd1, e);
    send(2'd2, e);
    send(2'd2, e);
    @(negedge clk);
    chk("t2_no_confirm", 32'(cmd_data), 0);
    send(2'd2, e1);
    expect_pulse(12'd2, e1);
    expect_pulse(12'd0, e1 + HOLD);
    @(negedge clk);
    chk("t2_cmd_data", 32'(cmd_data), 2);
    wait_cyc(e1 + HOLD + 2);

    // 3: 1,1,0 -> back to IDLE; class 3 also drops the candidate.
    send(2'd1, e);
    send(2'd1, e);
    send(2'd0, e);
    @(negedge clk);
    chk("t3_busy_after_0", 32'(busy), 0);
    chk("t3_cmd_data", 32'(cmd_data), 0);
    send(2'd1, e);
    @(negedge clk);
    chk("t3_busy_cand", 32'(busy), 1);
    send(2'd3, e);
    @(negedge clk);
    chk("t3_busy_after_3", 32'(busy), 0);
    chk("t3_ready", 32'(frame_ready), 1);

    // 5: reconfirm exactly on the timeout cycle -> no pulse, timer restarts.
    send(2'd1, e);
    send(2'd1, e);
    send(2'd1, e1);
    expect_pulse(12'd1, e1);
    send(2'd1, e);
    send(2'd1, e);
    wait_cyc(e1 + HOLD - 2);
    send(2'd1, e2);
    chk("t5_reconfirm_edge", 32'(e2), 32'(e1 + HOLD));
    expect_pulse(12'd0, e2 + HOLD);
    @(negedge clk);
    chk("t5_cmd_held", 32'(cmd_data), 1);
    wait_cyc(e2 + HOLD - 1);
    chk("t5_restart_before", 32'(cmd_data), 1);
    wait_cyc(e2 + HOLD);
    chk("t5_restart_expired", 32'(cmd_data), 0);
    wait_cyc(e2 + HOLD + 2);

    // 6: asynchronous reset during COOLDOWN with cmd_data=2.
    send(2'd2, e);
    send(2'd2, e);
    send(2'd2, e1);
    expect_pulse(12'd2, e1);
    @(negedge clk);
    chk("t6_in_cooldown", 32'(frame_ready), 0);
    chk("t6_cmd_before", 32'(cmd_data), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_cmd", 32'(cmd_data), 0);
    chk("t6_async_ready", 32'(frame_ready), 1);
    chk("t6_async_valid", 32'(cmd_valid), 0);
    chk("t6_async_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_post_cmd", 32'(cmd_data), 0);
    chk("t6_post_ready", 32'(frame_ready), 1);
    chk("t6_post_valid", 32'(cmd_valid), 0);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
